// File: rtl/regfile_sb.sv
// Multi-ported integer register file with write-to-read bypass and a
// per-register busy scoreboard; register 0 always reads as zero.
module regfile_sb #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NREGS = 32,
  parameter int unsigned NRD   = 2,
  parameter int unsigned NWR   = 2,
  parameter int unsigned AW    = $clog2(NREGS)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NRD*AW-1:0]             ra,
  output logic [NRD*WIDTH-1:0]          rd,
  output logic [NRD-1:0]                rbusy,
  input  logic [NWR-1:0]                we,
  input  logic [NWR*AW-1:0]             wa,
  input  logic [NWR*WIDTH-1:0]          wd,
  input  logic                          iss_valid,
  input  logic [AW-1:0]                 iss_addr,
  output logic                          iss_ready,
  output logic [$clog2(NREGS+1)-1:0]    nbusy
);

  localparam int unsigned CW = $clog2(NREGS + 1);

  logic [WIDTH-1:0] rf [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] wr_hit;
  logic [NREGS-1:0] busy_eff;
  logic [NREGS-1:0] iss_set;
  logic [NREGS-1:0] busy_nxt;
  logic [CW-1:0]    n_set;
  logic [CW-1:0]    n_clr;

  // Per-register mask of this cycle's effective writes (r0 excluded)
  always_comb begin
    wr_hit = '0;
    for (int j = 0; j < int'(NWR); j++) begin
      if (we[j] && (wa[j*AW +: AW] != '0)) begin
        wr_hit[wa[j*AW +: AW]] = 1'b1;
      end
    end
  end

  assign busy_eff  = busy & ~wr_hit;
  assign iss_ready = (iss_addr == '0) || !busy_eff[iss_addr];

  always_comb begin
    iss_set = '0;
    if (iss_valid && iss_ready && (iss_addr != '0)) begin
      iss_set[iss_addr] = 1'b1;
    end
  end

  // Issue set wins over a same-cycle writeback clear
  assign busy_nxt = busy_eff | iss_set;

  // Count only bits that actually flip, so duplicate writes count once
  always_comb begin
    n_set = '0;
    n_clr = '0;
    for (int r = 0; r < int'(NREGS); r++) begin
      n_set = n_set + CW'(busy_nxt[r] & ~busy[r]);
      n_clr = n_clr + CW'(busy[r] & ~busy_nxt[r]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy  <= '0;
      nbusy <= '0;
    end else begin
      busy  <= busy_nxt;
      nbusy <= nbusy + n_set - n_clr;
    end
  end

  // Later ports overwrite earlier ones, so the highest index wins a collision
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < int'(NREGS); r++) begin
        rf[r] <= '0;
      end
    end else begin
      for (int j = 0; j < int'(NWR); j++) begin
        if (we[j] && (wa[j*AW +: AW] != '0)) begin
          rf[wa[j*AW +: AW]] <= wd[j*WIDTH +: WIDTH];
        end
      end
    end
  end

  // Read ports: array value, overridden by the highest-index matching write
  always_comb begin
    rd    = '0;
    rbusy = '0;
    for (int i = 0; i < int'(NRD); i++) begin
      if (ra[i*AW +: AW] != '0) begin
        rd[i*WIDTH +: WIDTH] = rf[ra[i*AW +: AW]];
        rbusy[i]             = busy[ra[i*AW +: AW]];
        for (int j = 0; j < int'(NWR); j++) begin
          if (we[j] && (wa[j*AW +: AW] == ra[i*AW +: AW])) begin
            rd[i*WIDTH +: WIDTH] = wd[j*WIDTH +: WIDTH];
            rbusy[i]             = 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: a driver pushes expected responses from a
// behavioural model, a monitor pops and compares them on the falling edge.
module tb_regfile_sb;

  localparam int WIDTH = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int NWR   = 2;
  localparam int AW    = 5;
  localparam int CW    = 6;

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic [NRD*AW-1:0]      ra = '0;
  logic [NRD*WIDTH-1:0]   rd;
  logic [NRD-1:0]         rbusy;
  logic [NWR-1:0]         we = '0;
  logic [NWR*AW-1:0]      wa = '0;
  logic [NWR*WIDTH-1:0]   wd = '0;
  logic                   iss_valid = 1'b0;
  logic [AW-1:0]          iss_addr = '0;
  logic                   iss_ready;
  logic [CW-1:0]          nbusy;

  regfile_sb #(.WIDTH(WIDTH), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) dut (
    .clk(clk), .reset(reset), .ra(ra), .rd(rd), .rbusy(rbusy),
    .we(we), .wa(wa), .wd(wd), .iss_valid(iss_valid), .iss_addr(iss_addr),
    .iss_ready(iss_ready), .nbusy(nbusy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NRD*WIDTH-1:0] rd;
    logic [NRD-1:0]       rbusy;
    logic                 iss_ready;
    logic [CW-1:0]        nbusy;
    int                   id;
  } exp_t;

  exp_t sbq[$];

  logic [WIDTH-1:0] m_rf [NREGS];
  bit               m_busy [NREGS];
  bit               m_valid = 1'b0;
  int               step_id = 0;
  int               checks = 0;
  int               failures = 0;

  task automatic chk(input string name, input int id, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d got=%h expected=%h", name, id, act, exp);
    end
  endtask

  // Monitor: compare DUT outputs with the oldest queued expectation
  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      chk("rd",        e.id, 64'(rd),        64'(e.rd));
      chk("rbusy",     e.id, 64'(rbusy),     64'(e.rbusy));
      chk("iss_ready", e.id, 64'(iss_ready), 64'(e.iss_ready));
      chk("nbusy",     e.id, 64'(nbusy),     64'(e.nbusy));
    end
  end

  // Driver: apply one cycle of stimulus, queue the expected outputs, advance model
  task automatic step(input bit rst, input logic [AW-1:0] r0, input logic [AW-1:0] r1,
                      input logic [NWR-1:0] w_en, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                      input logic [WIDTH-1:0] d0, input logic [WIDTH-1:0] d1,
                      input bit iv, input logic [AW-1:0] ia);
    logic [AW-1:0]    rad [NRD];
    logic [AW-1:0]    wad [NWR];
    logic [WIDTH-1:0] wdd [NWR];
    exp_t             e;
    bit               written;
    int               cnt;
    @(posedge clk);
    #1;
    reset = rst; ra = {r1, r0}; we = w_en; wa = {a1, a0}; wd = {d1, d0};
    iss_valid = iv; iss_addr = ia;
    rad[0] = r0; rad[1] = r1; wad[0] = a0; wad[1] = a1; wdd[0] = d0; wdd[1] = d1;
    step_id++;
    e.id = step_id; e.rd = '0; e.rbusy = '0;
    for (int p = 0; p < NRD; p++) begin
      if (rad[p] != 0) begin
        logic [WIDTH-1:0] d;
        bit b;
        d = m_rf[rad[p]];
        b = m_busy[rad[p]];
        for (int j = NWR - 1; j >= 0; j--) begin
          if (w_en[j] && wad[j] == rad[p]) begin
            d = wdd[j];
            b = 1'b0;
            break;
          end
        end
        e.rd[p*WIDTH +: WIDTH] = d;
        e.rbusy[p] = b;
      end
    end
    written = 1'b0;
    for (int j = 0; j < NWR; j++) if (w_en[j] && wad[j] == ia) written = 1'b1;
    e.iss_ready = (ia == 0) || !m_busy[ia] || written;
    cnt = 0;
    for (int r = 0; r < NREGS; r++) cnt += int'(m_busy[r]);
    e.nbusy = CW'(cnt);
    if (m_valid) sbq.push_back(e);
    if (rst) begin
      for (int r = 0; r < NREGS; r++) begin
        m_rf[r] = '0;
        m_busy[r] = 1'b0;
      end
      m_valid = 1'b1;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (w_en[j] && wad[j] != 0) begin
          m_rf[wad[j]] = wdd[j];
          m_busy[wad[j]] = 1'b0;
        end
      end
      if (iv && e.iss_ready && ia != 0) m_busy[ia] = 1'b1;
    end
  endtask

  initial begin
    int wait_cyc;
    step(1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    step(1, 5, 31, 2'b00, 0, 0, 0, 0, 0, 0);
    // reset then read, write r5, read back
    step(0, 5, 31, 2'b00, 0, 0, 0, 0, 0, 5);
    step(0, 5, 31, 2'b01, 5, 0, 32'hDEADBEEF, 0, 0, 0);
    step(0, 5, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    // bypass with collision on r7
    step(0, 7, 7, 2'b11, 7, 7, 32'h11, 32'h22, 0, 0);
    step(0, 7, 5, 2'b00, 0, 0, 0, 0, 0, 0);
    // register 0 writes and issues are ignored
    step(0, 0, 0, 2'b01, 0, 0, 32'hFFFFFFFF, 0, 1, 0);
    step(0, 0, 7, 2'b00, 0, 0, 0, 0, 0, 0);
    // scoreboard round trip on r3
    step(0, 3, 0, 2'b00, 0, 0, 0, 0, 1, 3);
    step(0, 3, 0, 2'b00, 0, 0, 0, 0, 1, 3);
    step(0, 3, 0, 2'b10, 0, 3, 0, 32'h5, 0, 3);
    step(0, 3, 0, 2'b00, 0, 0, 0, 0, 0, 3);
    // simultaneous issue and write on busy r9
    step(0, 9, 0, 2'b00, 0, 0, 0, 0, 1, 9);
    step(0, 9, 0, 2'b01, 9, 0, 32'hAB, 0, 1, 9);
    step(0, 9, 0, 2'b00, 0, 0, 0, 0, 0, 9);
    // reset mid-operation with pending reservations and a write
    step(0, 1, 2, 2'b00, 0, 0, 0, 0, 1, 1);
    step(0, 1, 2, 2'b00, 0, 0, 0, 0, 1, 2);
    step(0, 4, 0, 2'b00, 0, 0, 0, 0, 1, 4);
    step(0, 1, 4, 2'b00, 0, 0, 0, 0, 0, 4);
    step(1, 1, 2, 2'b01, 1, 0, 32'h7, 0, 1, 6);
    step(0, 1, 4, 2'b00, 0, 0, 0, 0, 0, 1);
    // randomized traffic, addresses often narrowed to force collisions
    for (int n = 0; n < 3000; n++) begin
      int hi;
      hi = ($urandom_range(0, 3) == 0) ? 31 : 7;
      step($urandom_range(0, 299) == 0,
           AW'($urandom_range(0, hi)), AW'($urandom_range(0, hi)),
           NWR'($urandom_range(0, 3)),
           AW'($urandom_range(0, hi)), AW'($urandom_range(0, hi)),
           $urandom, $urandom,
           $urandom_range(0, 1) == 1, AW'($urandom_range(0, hi)));
    end
    wait_cyc = 0;
    while (sbq.size() > 0 && wait_cyc < 10) begin
      @(posedge clk);
      wait_cyc++;
    end
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d expected=0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
